mem_dtack_gen: RTL and testbench

//  Wait-state DTACK generator for on-board RAM and ROM. Consumes the active-low

---
 rtl/mem_dtack_gen.sv | 132 +++++++++++++
 tb/tb_mem_dtack_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_dtack_gen.sv
// Wait-state DTACK generator for on-board RAM and ROM.
// Takes the active-low chip selects from address decode and produces a
// registered DTACK after a per-device number of wait clocks. The DTACK output
// is gated combinationally with as_n, so it releases the moment the CPU ends
// the bus cycle and can never overlap the next cycle.
module mem_dtack_gen #(
  parameter int RAM_WAIT = 0,   // wait clocks after RAM select
  parameter int ROM_WAIT = 2,   // wait clocks after ROM select
  parameter int CNT_W    = 4    // wait counter width
) (
  input  logic clk,
  input  logic por_n,
  input  logic as_n,
  input  logic ram_sel_n,
  input  logic rom_sel_n,
  output logic mem_dtack_n,
  output logic busy,
  output logic sel_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Counter preload is W-1: the WAIT state spends one clock at count 0
  // before moving to ACK, so total select-to-DTACK latency is W+1 clocks.
  localparam logic [CNT_W-1:0] RAM_LD = (RAM_WAIT > 0) ? CNT_W'(RAM_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0] ROM_LD = (ROM_WAIT > 0) ? CNT_W'(ROM_WAIT - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;          // 1 = cycle belongs to ROM
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             err_seen_q, err_seen_d; // both-selects condition already flagged

  logic ram_only, rom_only, both_sel, src_sel_n;

  assign ram_only  = ~ram_sel_n &  rom_sel_n;
  assign rom_only  =  ram_sel_n & ~rom_sel_n;
  assign both_sel  = ~ram_sel_n & ~rom_sel_n;
  // Select of the device that owns the current cycle; latched at entry so a
  // glitch on the other select cannot steal or abort the cycle.
  assign src_sel_n = src_q ? rom_sel_n : ram_sel_n;

  // Next-state, wait counter, ack and error-pulse logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_seen_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ram_only) begin
          src_d = 1'b0;
          if (RAM_WAIT == 0) begin
            state_d = S_ACK;
          end else begin
            cnt_d   = RAM_LD;
            state_d = S_WAIT;
          end
        end else if (rom_only) begin
          src_d = 1'b1;
          if (ROM_WAIT == 0) begin
            state_d = S_ACK;
          end else begin
            cnt_d   = ROM_LD;
            state_d = S_WAIT;
          end
        end else if (both_sel) begin
          // Decode fault: never acknowledge, let the watchdog raise BERR.
          // Flag it once per occurrence rather than every clock it persists.
          err_seen_d = 1'b1;
          err_d      = ~err_seen_q;
        end
      end
      S_WAIT: begin
        if (as_n || src_sel_n) begin
          // CPU gave up or decode moved away: drop the cycle silently.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        if (as_n) begin
          state_d = S_IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; power-on reset clears everything without a clock.
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      src_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_seen_q <= err_seen_d;
    end
  end

  // Only the as_n gate is combinational, so DTACK drops as soon as AS rises.
  assign mem_dtack_n = ~(ack_q & ~as_n);
  assign busy        = busy_q;
  assign sel_err     = err_q;

endmodule

// File: tb/tb_mem_dtack_gen.sv
// Directed bench for mem_dtack_gen: default instance (RAM 0 / ROM 2 waits)
// plus a ROM_WAIT=5 instance for the abort scenario, sharing all inputs.
module tb_mem_dtack_gen;

  logic clk = 1'b0;
  logic por_n, as_n, ram_sel_n, rom_sel_n;
  logic dtack_n, busy, sel_err;
  logic dtack5_n, busy5, sel_err5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_dtack_gen u_dut (
    .clk(clk), .por_n(por_n), .as_n(as_n),
    .ram_sel_n(ram_sel_n), .rom_sel_n(rom_sel_n),
    .mem_dtack_n(dtack_n), .busy(busy), .sel_err(sel_err)
  );

  mem_dtack_gen #(.RAM_WAIT(0), .ROM_WAIT(5), .CNT_W(4)) u_dut5 (
    .clk(clk), .por_n(por_n), .as_n(as_n),
    .ram_sel_n(ram_sel_n), .rom_sel_n(rom_sel_n),
    .mem_dtack_n(dtack5_n), .busy(busy5), .sel_err(sel_err5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: count edges from the sampling edge until DTACK is seen low.
  // Edge 0 samples the select and DTACK appears after edge W+1, i.e. W+2 edges.
  task automatic run_cycle(input string tag, input bit is_rom, input int exp_edges);
    int edges = 0;
    as_n = 1'b0;
    if (is_rom) rom_sel_n = 1'b0; else ram_sel_n = 1'b0;
    do begin
      tick();
      edges++;
    end while (dtack_n && edges < 20);
    chk({tag, "_lat"}, edges, exp_edges);
    as_n = 1'b1; ram_sel_n = 1'b1; rom_sel_n = 1'b1;
    #1;
    chk({tag, "_rel"}, dtack_n, 1'b1);
    chk({tag, "_busy_ack"}, busy, 1'b1);
    tick();  // as_n-high gap clock: ACK -> IDLE
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    por_n = 1'b0; as_n = 1'b1; ram_sel_n = 1'b1; rom_sel_n = 1'b1;
    #1;
    chk("rst_dtack", dtack_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", sel_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 por_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    // RAM, zero wait states
    as_n = 1'b0; ram_sel_n = 1'b0;
    tick();
    chk("ram_e0_dtack", dtack_n, 1'b1);
    chk("ram_e0_busy", busy, 1'b1);
    tick();
    chk("ram_e1_dtack", dtack_n, 1'b0);
    as_n = 1'b1; ram_sel_n = 1'b1;
    #1;
    chk("ram_as_rel", dtack_n, 1'b1);
    chk("ram_busy_hold", busy, 1'b1);
    tick();
    chk("ram_idle", busy, 1'b0);

    // ROM, two wait states
    as_n = 1'b0; rom_sel_n = 1'b0;
    tick();
    chk("rom_e0_dtack", dtack_n, 1'b1);
    chk("rom_e0_busy", busy, 1'b1);
    tick();
    chk("rom_e1_dtack", dtack_n, 1'b1);
    chk("rom_e1_busy", busy, 1'b1);
    tick();
    chk("rom_e2_dtack", dtack_n, 1'b1);
    chk("rom_e2_busy", busy, 1'b1);
    tick();
    chk("rom_e3_dtack", dtack_n, 1'b0);
    chk("rom5_no_dtack", dtack5_n, 1'b1);
    as_n = 1'b1; rom_sel_n = 1'b1;
    #1;
    chk("rom_as_rel", dtack_n, 1'b1);
    tick();
    chk("rom_idle", busy, 1'b0);
    chk("rom5_abort_idle", busy5, 1'b0);

    // Abort: ROM_WAIT=5 instance, as_n rises after two clocks
    as_n = 1'b0; rom_sel_n = 1'b0;
    tick();
    tick();
    chk("abort_busy", busy5, 1'b1);
    chk("abort_dtack_pre", dtack5_n, 1'b1);
    as_n = 1'b1; rom_sel_n = 1'b1;
    tick();
    chk("abort_idle", busy5, 1'b0);
    chk("abort_main_idle", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_dtack_post", dtack5_n, 1'b1);
    end

    // Abort by select release while as_n stays low
    as_n = 1'b0; rom_sel_n = 1'b0;
    tick();
    chk("selrel_busy", busy, 1'b1);
    rom_sel_n = 1'b1;
    tick();
    chk("selrel_idle", busy, 1'b0);
    tick();
    chk("selrel_dtack", dtack_n, 1'b1);
    as_n = 1'b1;
    tick();

    // Both selects low: single sel_err pulse, no DTACK
    as_n = 1'b0; ram_sel_n = 1'b0; rom_sel_n = 1'b0;
    tick();
    chk("both_err", sel_err, 1'b1);
    chk("both_busy", busy, 1'b0);
    chk("both_dtack", dtack_n, 1'b1);
    tick();
    chk("both_err_pulse", sel_err, 1'b0);
    chk("both_dtack2", dtack_n, 1'b1);
    as_n = 1'b1; ram_sel_n = 1'b1; rom_sel_n = 1'b1;
    tick();
    chk("both_err_clr", sel_err, 1'b0);

    // Back-to-back RAM, ROM, RAM with one-clock as_n-high gaps
    run_cycle("b2b_ram0", 1'b0, 2);
    run_cycle("b2b_rom", 1'b1, 4);
    run_cycle("b2b_ram1", 1'b0, 2);

    // Asynchronous reset mid-cycle: main in ACK, ROM_WAIT=5 instance in WAIT
    as_n = 1'b0; rom_sel_n = 1'b0;
    repeat (4) tick();
    chk("prerst_dtack", dtack_n, 1'b0);
    chk("prerst_busy5", busy5, 1'b1);
    #2 por_n = 1'b0;
    #1;
    chk("arst_dtack", dtack_n, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_busy5", busy5, 1'b0);
    chk("arst_dtack5", dtack5_n, 1'b1);
    as_n = 1'b1; rom_sel_n = 1'b1;
    #2 por_n = 1'b1;
    tick();
    chk("arst_rel_busy", busy, 1'b0);
    chk("arst_rel_dtack", dtack_n, 1'b1);

    // Normal RAM cycle after reset recovery
    run_cycle("post_rst_ram", 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
